iter_muldiv: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the EX stage. It generalises the fixed 32-bit divider to a configurable operand width and adds iterative multiply on the same datapath. It uses one start/ready handshake for all four HI/LO operations (mult, multu, div, divu). The EX stage raises its stall request while a started operation has not returned `ready_o`. On `ready_o`, the EX stage writes `result_o[2*WIDTH-1:WIDTH]` to HI and `result_o[WIDTH-1:0]` to LO.

---
 rtl/iter_muldiv_if.sv | 24 ++
 rtl/iter_muldiv.sv | 147 ++++++++++++++
 tb/tb_iter_muldiv.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/iter_muldiv_if.sv
// rtl/iter_muldiv_if.sv - start/ready handshake bundle between the EX stage and iter_muldiv
// The EX stage drives the master side and the multiply/divide unit drives the slave side.
interface iter_muldiv_if #(
  parameter int WIDTH = 32
);
  logic                 start_i;
  logic                 annul_i;
  logic [1:0]           op_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 busy_o;
  logic                 ready_o;
  logic [2*WIDTH-1:0]   result_o;

  modport master (
    output start_i, annul_i, op_i, opdata1_i, opdata2_i,
    input  busy_o, ready_o, result_o
  );

  modport slave (
    input  start_i, annul_i, op_i, opdata1_i, opdata2_i,
    output busy_o, ready_o, result_o
  );
endinterface

// File: rtl/iter_muldiv.sv
// rtl/iter_muldiv.sv - iterative mult/multu/div/divu unit for the EX stage (HI/LO result)
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply on magnitudes instead of shift-add.
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         resetn,
  iter_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic                 is_div_q;
  logic                 neg_q;
  logic                 rneg_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   result_q;

  logic                 signed_op;
  logic                 s1;
  logic                 s2;
  logic [WIDTH-1:0]     mag1;
  logic [WIDTH-1:0]     mag2;
  logic                 div_zero;

  assign signed_op = ~bus.op_i[0];
  assign s1        = signed_op & bus.opdata1_i[WIDTH-1];
  assign s2        = signed_op & bus.opdata2_i[WIDTH-1];
  assign mag1      = s1 ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
  assign mag2      = s2 ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
  assign div_zero  = bus.op_i[1] & (bus.opdata2_i == '0);

  // hi_q is the partial remainder / upper accumulator, lo_q the dividend-in-quotient-out / multiplier shifter.
  logic [WIDTH:0]       trial;
  logic [WIDTH:0]       diff;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     hi_d;
  logic [WIDTH-1:0]     lo_d;

  always_comb begin
    trial = {hi_q, lo_q[WIDTH-1]};
    diff  = trial - {1'b0, b_q};
    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (is_div_q) begin
      if (!diff[WIDTH]) begin
        hi_d = diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = trial[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [2*WIDTH-1:0]   final_res;

  always_comb begin
    prod      = {hi_d, lo_d};
    quo_fix   = neg_q  ? (~lo_d + 1'b1) : lo_d;
    rem_fix   = rneg_q ? (~hi_d + 1'b1) : hi_d;
    final_res = is_div_q ? {rem_fix, quo_fix} : (neg_q ? (~prod + 1'b1) : prod);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0]   fast_prod;
  logic [2*WIDTH-1:0]   fast_res;

  always_comb begin
    fast_prod = {{WIDTH{1'b0}}, mag1} * {{WIDTH{1'b0}}, mag2};
    fast_res  = (s1 ^ s2) ? (~fast_prod + 1'b1) : fast_prod;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (bus.start_i && !bus.annul_i) begin
            is_div_q <= bus.op_i[1];
            neg_q    <= s1 ^ s2;
            rneg_q   <= s1;
            hi_q     <= '0;
            lo_q     <= mag1;
            b_q      <= mag2;
            cnt_q    <= '0;
            if (div_zero) begin
              result_q <= {bus.opdata1_i, {WIDTH{1'b1}}};
              state_q  <= DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!bus.op_i[1]) begin
              result_q <= fast_res;
              state_q  <= DONE;
            end
`endif
            else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.annul_i) begin
            state_q <= IDLE;
          end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            if (cnt_q == CW'(WIDTH - 1)) begin
              result_q <= final_res;
              state_q  <= DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o   = (state_q == CALC);
  assign bus.ready_o  = (state_q == DONE);
  assign bus.result_o = result_q;
endmodule

// File: tb/tb_iter_muldiv.sv
// tb/tb_iter_muldiv.sv - scoreboard bench for iter_muldiv with hand-computed directed vectors
// Expected results are queued at issue; a negedge monitor pops and compares on ready_o.
module tb_iter_muldiv;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = W + 1;
`endif
  localparam int LAT_DIV = W + 1;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  typedef struct {
    logic [2*W-1:0] res;
    int             cyc;
  } exp_t;

  logic clk;
  logic resetn;
  int   cyc;
  int   checks;
  int   errors;
  logic [2*W-1:0] last_exp;
  exp_t sb[$];

  iter_muldiv_if #(.WIDTH(W)) bus ();

  iter_muldiv #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && bus.ready_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: cyc %0d result %h, required no ready", cyc, bus.result_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", bus.result_o, e.res);
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL ready_cycle: got %0d, required %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] res, input int lat, input bit push);
    bus.op_i      = op;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.start_i   = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    if (push) begin
      sb.push_back('{res, cyc + lat - 1});
      last_exp = res;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending %0d, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    int busy_n;
    checks        = 0;
    errors        = 0;
    last_exp      = '0;
    resetn        = 1'b0;
    bus.start_i   = 1'b0;
    bus.annul_i   = 1'b0;
    bus.op_i      = 2'b00;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, bus.busy_o}, 64'd0);
    check("reset_ready", {63'd0, bus.ready_o}, 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    issue(OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, LAT_DIV, 1'b1);
    n = 0;
    busy_n = 0;
    while (!bus.ready_o && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.busy_o) busy_n++;
    end
    check("divu_busy_cycles", 64'(busy_n), 64'd32);
    drain();

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, LAT_DIV, 1'b1);
    drain();
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, LAT_DIV, 1'b1);
    drain();
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, LAT_DIV, 1'b1);
    drain();
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, LAT_DIV, 1'b1);
    drain();
    issue(OP_DIV, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1, 1'b1);
    drain();
    issue(OP_DIVU, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1, 1'b1);
    drain();
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, LAT_MUL, 1'b1);
    drain();
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, LAT_MUL, 1'b1);
    drain();
    issue(OP_MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 64'd24, LAT_MUL, 1'b1);
    drain();

    bus.annul_i = 1'b1;
    issue(OP_DIVU, 32'd9, 32'd3, 64'd0, LAT_DIV, 1'b0);
    bus.annul_i = 1'b0;
    check("start_annul_busy", {63'd0, bus.busy_o | bus.ready_o}, 64'd0);
    repeat (3) @(negedge clk);

    issue(OP_DIVU, 32'd1000, 32'd3, 64'd0, LAT_DIV, 1'b0);
    repeat (10) @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk);
    #1;
    bus.annul_i = 1'b0;
    check("annul_busy", {63'd0, bus.busy_o}, 64'd0);
    check("annul_ready", {63'd0, bus.ready_o}, 64'd0);
    check("annul_result_held", bus.result_o, last_exp);
    repeat (40) @(negedge clk);
    issue(OP_DIVU, 32'd1000, 32'd3, {32'd1, 32'd333}, LAT_DIV, 1'b1);
    drain();

    issue(OP_DIVU, 32'd1000, 32'd3, 64'd0, LAT_DIV, 1'b0);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midreset_busy", {63'd0, bus.busy_o}, 64'd0);
    check("midreset_ready", {63'd0, bus.ready_o}, 64'd0);
    check("midreset_result", bus.result_o, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);

    issue(OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, LAT_DIV, 1'b1);
    n = 0;
    while (!bus.ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready_o) begin
      checks++;
      errors++;
      $display("FAIL b2b_first_ready: got timeout, required ready");
    end
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, LAT_MUL, 1'b1);
    check("b2b_no_idle", {63'd0, bus.busy_o | bus.ready_o}, 64'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end
endmodule
